// File: rtl/disp_wr_arbiter.sv
`default_nettype none
// ==== disp_wr_arbiter : arbitrates two req/ack writers onto four display digit registers ====
// ==== Option: DISP_ARB_RR_EN (round-robin on ties, else B wins)  | rev 1.0                 ====
module disp_wr_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic [1:0]    a_sel,
  input  logic [DW-1:0] a_data,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [1:0]    b_sel,
  input  logic [DW-1:0] b_data,
  output logic          b_ack,
  output logic [DW-1:0] d0,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2,
  output logic [DW-1:0] d3,
  output logic          upd,
  output logic          last_grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          win_q, win_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic          lg_q, lg_d;
  logic          upd_q, upd_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] dig_q [4];
  logic [DW-1:0] dig_d [4];
  logic          pick;
  logic          win_req;

  // Tie-break between simultaneous requests; a lone request always wins.
  always_comb begin
    pick = b_req;
    if (a_req && b_req) begin
`ifdef DISP_ARB_RR_EN
      pick = ~lg_q;
`else
      pick = 1'b1;
`endif
    end
  end

  assign win_req = win_q ? b_req : a_req;
  assign sync_d  = {sync_q[0], 1'b1};

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    sel_d   = sel_q;
    data_d  = data_q;
    lg_d    = lg_q;
    upd_d   = 1'b0;
    a_ack_d = a_ack_q;
    b_ack_d = b_ack_q;
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];
    case (state_q)
      ST_IDLE: begin
        if (sync_q[1] && (a_req || b_req)) begin
          win_d   = pick;
          sel_d   = pick ? b_sel : a_sel;
          data_d  = pick ? b_data : a_data;
          lg_d    = pick;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        dig_d[sel_q] = data_q;
        upd_d        = 1'b1;
        a_ack_d      = ~win_q;
        b_ack_d      = win_q;
        state_d      = ST_ACK;
      end
      ST_ACK: begin
        // An early req drop still lands here, giving a single-cycle ack.
        if (!win_req) begin
          a_ack_d = 1'b0;
          b_ack_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b00;
      win_q   <= 1'b0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      lg_q    <= 1'b1;
      upd_q   <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      lg_q    <= lg_d;
      upd_q   <= upd_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign upd        = upd_q;
  assign last_grant = lg_q;
  assign d0         = dig_q[0];
  assign d1         = dig_q[1];
  assign d2         = dig_q[2];
  assign d3         = dig_q[3];

endmodule
`default_nettype wire

// File: tb/tb_disp_wr_arbiter.sv
`default_nettype none
// Directed bench for disp_wr_arbiter; expectations follow the DISP_ARB_RR_EN build setting.
module tb_disp_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req;
  logic [1:0] a_sel, b_sel;
  logic [7:0] a_data, b_data;
  logic       a_ack, b_ack, upd, last_grant;
  logic [7:0] d0, d1, d2, d3;
  int         tests = 0;
  int         fails = 0;
  int         waited;

  disp_wr_arbiter #(.DW(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_sel(a_sel), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_sel(b_sel), .b_data(b_data), .b_ack(b_ack),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .upd(upd), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dig(input logic [1:0] s);
    case (s)
      2'd0:    dig = d0;
      2'd1:    dig = d1;
      2'd2:    dig = d2;
      default: dig = d3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check("rst_d0", d0, 0); check("rst_d1", d1, 0);
    check("rst_d2", d2, 0); check("rst_d3", d3, 0);
    check("rst_a_ack", a_ack, 0); check("rst_b_ack", b_ack, 0);
    check("rst_upd", upd, 0); check("rst_last_grant", last_grant, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Called with the winner's request already pending in IDLE.
  task automatic serve(input logic w, input logic [1:0] s, input logic [7:0] val);
    @(negedge clk);
    check("srv_last_grant", last_grant, w);
    check("srv_no_early_ack", w ? b_ack : a_ack, 0);
    @(negedge clk);
    check("srv_ack_win", w ? b_ack : a_ack, 1);
    check("srv_ack_lose", w ? a_ack : b_ack, 0);
    check("srv_upd", upd, 1);
    check("srv_digit", dig(s), val);
    if (w) b_req = 1'b0; else a_req = 1'b0;
    @(negedge clk);
    check("srv_ack_drop", w ? b_ack : a_ack, 0);
    check("srv_upd_low", upd, 0);
  endtask

  initial begin
    reset = 1'b0;
    a_req = 1'b0; a_sel = 2'd0; a_data = 8'h00;
    b_req = 1'b0; b_sel = 2'd0; b_data = 8'h00;
    do_reset();

    // Single A write to digit 2, req held one extra cycle.
    a_req = 1'b1; a_sel = 2'd2; a_data = 8'h3F;
    @(negedge clk);
    check("t1_grant_lg", last_grant, 0);
    check("t1_d2_pre", d2, 8'h00);
    check("t1_upd_pre", upd, 0);
    @(negedge clk);
    check("t1_d2", d2, 8'h3F);
    check("t1_upd", upd, 1);
    check("t1_a_ack", a_ack, 1);
    check("t1_b_ack", b_ack, 0);
    check("t1_d0", d0, 0); check("t1_d1", d1, 0); check("t1_d3", d3, 0);
    @(negedge clk);
    check("t1_upd_pulse", upd, 0);
    check("t1_a_ack_hold", a_ack, 1);
    a_req = 1'b0;
    @(negedge clk);
    check("t1_a_ack_low", a_ack, 0);
    check("t1_b_ack_low", b_ack, 0);

    do_reset();

    // Simultaneous contest on digit 0.
    a_sel = 2'd0; a_data = 8'h06; b_sel = 2'd0; b_data = 8'h5B;
    a_req = 1'b1; b_req = 1'b1;
`ifdef DISP_ARB_RR_EN
    serve(1'b0, 2'd0, 8'h06);
    serve(1'b1, 2'd0, 8'h5B);
    check("rr_d0_final", d0, 8'h5B);
    a_req = 1'b1; b_req = 1'b1;
    serve(1'b0, 2'd0, 8'h06);
    serve(1'b1, 2'd0, 8'h5B);
    check("rr_d0_final2", d0, 8'h5B);
`else
    serve(1'b1, 2'd0, 8'h5B);
    b_req = 1'b1;
    serve(1'b1, 2'd0, 8'h5B);
    b_req = 1'b1;
    serve(1'b1, 2'd0, 8'h5B);
    serve(1'b0, 2'd0, 8'h06);
    check("fp_d0_final", d0, 8'h06);
`endif

    // Data and sel changed after the grant must be ignored.
    a_req = 1'b1; a_sel = 2'd1; a_data = 8'h11;
    @(negedge clk);
    a_data = 8'h22; a_sel = 2'd3;
    @(negedge clk);
    check("t4_d1", d1, 8'h11);
    check("t4_d3", d3, 8'h00);
    check("t4_a_ack", a_ack, 1);
    a_req = 1'b0;
    @(negedge clk);
    check("t4_a_ack_low", a_ack, 0);

    // Reset asserted during the WR cycle of a B write.
    b_req = 1'b1; b_sel = 2'd3; b_data = 8'h7F;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_d3", d3, 8'h00);
    check("t5_d0", d0, 8'h00);
    check("t5_b_ack", b_ack, 0);
    check("t5_upd", upd, 0);
    check("t5_last_grant", last_grant, 1);
    @(negedge clk);
    check("t5_d3_held", d3, 8'h00);
    reset = 1'b1;
    waited = 0;
    while (!b_ack && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("t5_regrant_ack", b_ack, 1);
    check("t5_regrant_d3", d3, 8'h7F);
    b_req = 1'b0;
    @(negedge clk);
    check("t5_b_ack_low", b_ack, 0);

    // B drops req during WR while A becomes pending.
    b_req = 1'b1; b_sel = 2'd1; b_data = 8'hAA;
    @(negedge clk);
    check("t6_grant_lg", last_grant, 1);
    b_req = 1'b0;
    a_req = 1'b1; a_sel = 2'd2; a_data = 8'hC3;
    @(negedge clk);
    check("t6_b_ack", b_ack, 1);
    check("t6_upd", upd, 1);
    check("t6_d1", d1, 8'hAA);
    check("t6_a_ack", a_ack, 0);
    @(negedge clk);
    check("t6_b_ack_1cyc", b_ack, 0);
    check("t6_a_ack_idle", a_ack, 0);
    check("t6_upd_low", upd, 0);
    @(negedge clk);
    check("t6_a_grant_lg", last_grant, 0);
    check("t6_a_ack_wr", a_ack, 0);
    @(negedge clk);
    check("t6_a_ack", a_ack, 1);
    check("t6_d2", d2, 8'hC3);
    a_req = 1'b0;
    @(negedge clk);
    check("t6_a_ack_low", a_ack, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
